obstacle_scroller: RTL and testbench

Obstacle producer for the T-rex game: spawns one ground obstacle at a time at the right screen edge and scrolls it left once per frame tick. It drives the obstacle position and size buses (`obs_x`, `obs_h`, `obs_w`) that the collision detector consumes, and freezes when that detector reports a hit. Speed ramps with the number of obstacles cleared.

---
 rtl/trex_pkg.sv | 33 +++
 rtl/obstacle_scroller_if.sv | 27 ++
 rtl/lfsr16.sv | 22 ++
 rtl/obstacle_scroller.sv | 112 +++++++++++
 tb/tb_obstacle_scroller.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/trex_pkg.sv
// Shared T-rex game types: FSM state codes, obstacle type table, LFSR mask, coordinate widths.
// Pure definitions; no latency, no backpressure.
package trex_pkg;

    localparam int X_W = 11;
    localparam int H_W = 7;
    localparam int W_W = 8;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_GAP    = 2'd1;
    localparam state_t ST_SCROLL = 2'd2;
    localparam state_t ST_FROZEN = 2'd3;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    function automatic logic [H_W-1:0] type_h(input logic [1:0] t);
        case (t)
            2'd1, 2'd2: type_h = 7'd50;
            default:    type_h = 7'd35;
        endcase
    endfunction

    function automatic logic [W_W-1:0] type_w(input logic [1:0] t);
        case (t)
            2'd0:    type_w = 8'd17;
            2'd1:    type_w = 8'd25;
            2'd2:    type_w = 8'd51;
            default: type_w = 8'd34;
        endcase
    endfunction

endpackage

// File: rtl/obstacle_scroller_if.sv
// Control strobes in, obstacle position/size and run status out.
// Plain wires; no latency, no flow control.
interface obstacle_scroller_if;
    import trex_pkg::*;

    logic           tick;
    logic           start;
    logic           collided;
    logic [X_W-1:0] obs_x;
    logic [H_W-1:0] obs_h;
    logic [W_W-1:0] obs_w;
    logic           obs_valid;
    logic [3:0]     speed;
    logic [15:0]    passed;
    logic           frozen;

    modport master (
        output tick, start, collided,
        input  obs_x, obs_h, obs_w, obs_valid, speed, passed, frozen
    );

    modport slave (
        input  tick, start, collided,
        output obs_x, obs_h, obs_w, obs_valid, speed, passed, frozen
    );

endinterface

// File: rtl/lfsr16.sv
// 16-bit right-shifting Galois LFSR used to pick obstacle types and gaps.
// Latency: advances one step per enabled edge; no backpressure.
module lfsr16
    import trex_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED;
        end else if (en) begin
            q <= (q >> 1) ^ (q[0] ? LFSR_MASK : 16'h0000);
        end
    end

endmodule

// File: rtl/obstacle_scroller.sv
// Spawns one ground obstacle at the right edge and scrolls it left per tick; speed ramps with clears.
// Latency: all outputs registered, one edge after the input cycle; no backpressure, freezes on collision.
module obstacle_scroller
    import trex_pkg::*;
#(
    parameter int          SCREEN_W   = 640,
    parameter int          SPEED_INIT = 4,
    parameter int          SPEED_MAX  = 12,
    parameter int          STEP_EVERY = 8,
    parameter int          GAP_MIN    = 30,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    obstacle_scroller_if.slave bus
);

    if (GAP_MIN + 63 > 127) begin : g_gap_width_chk
        $error("GAP_MIN + 63 does not fit the 7-bit gap counter");
    end

    state_t         state;
    logic [6:0]     gap_cnt;
    logic [X_W-1:0] obs_x;
    logic [H_W-1:0] obs_h;
    logic [W_W-1:0] obs_w;
    logic           obs_valid;
    logic           frozen;
    logic [3:0]     speed;
    logic [15:0]    passed;
    logic [15:0]    passed_nx;
    logic [15:0]    lfsr_q;
    logic [X_W-1:0] speed_x;
    logic           active;
    logic           hit;
    logic           adv;

    assign active    = (state == ST_GAP) || (state == ST_SCROLL);
    assign hit       = active && bus.collided;
    // A tick only counts when neither a collision nor a restart claims the cycle.
    assign adv       = active && bus.tick && !bus.collided && !bus.start;
    assign passed_nx = passed + 16'd1;
    assign speed_x   = {{(X_W-4){1'b0}}, speed};

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (adv),
        .q   (lfsr_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            gap_cnt   <= '0;
            obs_x     <= X_W'(SCREEN_W);
            obs_h     <= '0;
            obs_w     <= '0;
            obs_valid <= 1'b0;
            speed     <= 4'(SPEED_INIT);
            passed    <= '0;
            frozen    <= 1'b0;
        end else if (hit) begin
            state  <= ST_FROZEN;
            frozen <= 1'b1;
        end else if (bus.start) begin
            state     <= ST_GAP;
            gap_cnt   <= 7'(GAP_MIN);
            obs_x     <= X_W'(SCREEN_W);
            obs_h     <= '0;
            obs_w     <= '0;
            obs_valid <= 1'b0;
            speed     <= 4'(SPEED_INIT);
            passed    <= '0;
            frozen    <= 1'b0;
        end else if (adv) begin
            if (state == ST_GAP) begin
                if (gap_cnt == 7'd0) begin
                    state     <= ST_SCROLL;
                    obs_x     <= X_W'(SCREEN_W);
                    obs_h     <= type_h(lfsr_q[1:0]);
                    obs_w     <= type_w(lfsr_q[1:0]);
                    obs_valid <= 1'b1;
                end else begin
                    gap_cnt <= gap_cnt - 7'd1;
                end
            end else if (obs_x < speed_x) begin
                state     <= ST_GAP;
                obs_valid <= 1'b0;
                obs_h     <= '0;
                obs_w     <= '0;
                obs_x     <= X_W'(SCREEN_W);
                passed    <= passed_nx;
                gap_cnt   <= 7'(GAP_MIN) + {1'b0, lfsr_q[5:0]};
                if ((passed_nx % 16'(STEP_EVERY)) == 16'd0 && passed_nx != 16'd0) begin
                    speed <= (speed >= 4'(SPEED_MAX)) ? 4'(SPEED_MAX) : speed + 4'd1;
                end
            end else begin
                obs_x <= obs_x - speed_x;
            end
        end
    end

    assign bus.obs_x     = obs_x;
    assign bus.obs_h     = obs_h;
    assign bus.obs_w     = obs_w;
    assign bus.obs_valid = obs_valid;
    assign bus.speed     = speed;
    assign bus.passed    = passed;
    assign bus.frozen    = frozen;

endmodule

// File: tb/tb_obstacle_scroller.sv
// Randomized bench for obstacle_scroller against a behavioural game model, with directed literal pins.
module tb_obstacle_scroller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    obstacle_scroller_if bus();

    obstacle_scroller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    // Behavioural model: phase 0 idle, 1 gap, 2 scroll, 3 frozen.
    int          m_phase, m_gap, m_x, m_h, m_w, m_valid, m_speed, m_passed, m_frozen;
    logic [15:0] m_lfsr;
    int          TH [4] = '{35, 50, 50, 35};
    int          TW [4] = '{17, 25, 51, 34};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic model_restart();
        m_phase = 1; m_gap = 30; m_x = 640; m_h = 0; m_w = 0; m_valid = 0;
        m_speed = 4; m_passed = 0; m_frozen = 0;
    endtask

    task automatic model_step(input bit r, input bit t, input bit s, input bit c);
        logic [15:0] cur;
        bit active;
        if (r) begin
            model_restart();
            m_phase = 0; m_gap = 0; m_lfsr = 16'hACE1;
            return;
        end
        active = (m_phase == 1 || m_phase == 2);
        if (active && c) begin
            m_phase = 3; m_frozen = 1;
            return;
        end
        if (s) begin
            model_restart();
            return;
        end
        if (!active || !t) return;
        cur = m_lfsr;
        m_lfsr = lfsr_next(m_lfsr);
        if (m_phase == 1) begin
            if (m_gap == 0) begin
                m_phase = 2; m_x = 640; m_valid = 1;
                m_h = TH[cur[1:0]]; m_w = TW[cur[1:0]];
            end else begin
                m_gap--;
            end
        end else if (m_x < m_speed) begin
            m_phase = 1; m_valid = 0; m_h = 0; m_w = 0; m_x = 640;
            m_passed = (m_passed + 1) % 65536;
            m_gap = 30 + int'(cur[5:0]);
            if (m_passed != 0 && m_passed % 8 == 0)
                m_speed = (m_speed + 1 > 12) ? 12 : m_speed + 1;
        end else begin
            m_x -= m_speed;
        end
    endtask

    task automatic cyc(input bit r, input bit t, input bit s, input bit c);
        @(negedge clk);
        rst = r; bus.tick = t; bus.start = s; bus.collided = c;
        model_step(r, t, s, c);
        @(posedge clk);
        #1;
        rst = 1'b0; bus.tick = 1'b0; bus.start = 1'b0; bus.collided = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            chk("obs_x",     bus.obs_x,     m_x);
            chk("obs_h",     bus.obs_h,     m_h);
            chk("obs_w",     bus.obs_w,     m_w);
            chk("obs_valid", bus.obs_valid, m_valid);
            chk("speed",     bus.speed,     m_speed);
            chk("passed",    bus.passed,    m_passed);
            chk("frozen",    bus.frozen,    m_frozen);
        end
    end

    initial begin
        int n;
        int first_h, first_w;
        bit seen8, seen64;
        bus.tick = 1'b0; bus.start = 1'b0; bus.collided = 1'b0;

        // Reset and idle ticks.
        cyc(1, 0, 0, 0);
        cmp_en = 1'b1;
        chk("rst_x", bus.obs_x, 640);
        chk("rst_valid", bus.obs_valid, 0);
        chk("rst_speed", bus.speed, 4);
        chk("rst_passed", bus.passed, 0);
        chk("rst_frozen", bus.frozen, 0);
        for (int i = 0; i < 20; i++) cyc(0, $urandom_range(1), 0, $urandom_range(1));
        chk("idle_valid", bus.obs_valid, 0);

        // First spawn after 31 ticks.
        cyc(0, 0, 1, 0);
        for (int i = 0; i < 30; i++) cyc(0, 1, 0, 0);
        chk("pre_spawn_valid", bus.obs_valid, 0);
        cyc(0, 1, 0, 0);
        chk("spawn_valid", bus.obs_valid, 1);
        chk("spawn_x", bus.obs_x, 640);
        first_h = m_h; first_w = m_w;

        // 640 / 4 scroll then despawn.
        for (int i = 0; i < 160; i++) cyc(0, 1, 0, 0);
        chk("scroll_zero_x", bus.obs_x, 0);
        chk("scroll_zero_valid", bus.obs_valid, 1);
        cyc(0, 1, 0, 0);
        chk("despawn_valid", bus.obs_valid, 0);
        chk("despawn_passed", bus.passed, 1);
        chk("despawn_x", bus.obs_x, 640);

        // Speed ramp and saturation under random ticks.
        n = 0; seen8 = 0; seen64 = 0;
        while (m_passed < 72 && n < 60000) begin
            cyc(0, $urandom_range(3) != 0, 0, 0);
            n++;
            if (m_passed == 8 && !seen8) begin
                seen8 = 1; chk("speed_at_8", bus.speed, 5);
            end
            if (m_passed == 64 && !seen64) begin
                seen64 = 1; chk("speed_at_64", bus.speed, 12);
            end
        end
        chk("ramp_timeout", n >= 60000, 0);
        chk("speed_sat_72", bus.speed, 12);

        // Collision at obs_x == 300 with same-cycle tick.
        cyc(0, 0, 1, 0);
        n = 0;
        while (!(m_phase == 2 && m_x == 300) && n < 2000) begin
            cyc(0, 1, 0, 0); n++;
        end
        chk("reach300_timeout", n >= 2000, 0);
        cyc(0, 1, 0, 1);
        chk("hit_frozen", bus.frozen, 1);
        chk("hit_x", bus.obs_x, 300);
        for (int i = 0; i < 50; i++) cyc(0, 1, 0, $urandom_range(1));
        chk("frozen_x", bus.obs_x, 300);
        chk("frozen_hold", bus.frozen, 1);

        // Restart from FROZEN.
        cyc(0, 0, 1, 0);
        chk("restart_passed", bus.passed, 0);
        chk("restart_speed", bus.speed, 4);
        chk("restart_valid", bus.obs_valid, 0);
        chk("restart_frozen", bus.frozen, 0);
        for (int i = 0; i < 30; i++) cyc(0, 1, 0, 0);
        chk("restart_prespawn", bus.obs_valid, 0);
        cyc(0, 1, 0, 0);
        chk("restart_spawn", bus.obs_valid, 1);

        // Random mix of ticks, restarts and collisions.
        for (int i = 0; i < 3000; i++)
            cyc(0, $urandom_range(1), $urandom_range(299) == 0, $urandom_range(149) == 0);

        // Reset mid-SCROLL.
        cyc(0, 0, 1, 0);
        n = 0;
        while (m_phase != 2 && n < 200) begin
            cyc(0, 1, 0, 0); n++;
        end
        chk("scroll_timeout", n >= 200, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk("midrst_x", bus.obs_x, 640);
        chk("midrst_h", bus.obs_h, 0);
        chk("midrst_w", bus.obs_w, 0);
        chk("midrst_valid", bus.obs_valid, 0);
        chk("midrst_speed", bus.speed, 4);
        chk("midrst_passed", bus.passed, 0);
        chk("midrst_frozen", bus.frozen, 0);
        for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0);
        chk("midrst_idle", bus.obs_valid, 0);
        cyc(0, 0, 1, 0);
        for (int i = 0; i < 31; i++) cyc(0, 1, 0, 0);
        chk("reseed_valid", bus.obs_valid, 1);
        chk("reseed_h", bus.obs_h, first_h);
        chk("reseed_w", bus.obs_w, first_w);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
